// File: rtl/yutorina_div.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU/REM/REMU) for the EX stage.
// One quotient bit per cycle; signed ops run on magnitudes and are sign-fixed at the end.
module yutorina_div #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              start,
    input  logic              signed_op,
    input  logic              flush,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_zero
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  counter;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic              sign_q;
    logic              sign_r;

    logic              accept;
    logic              div_by_zero;
    logic              neg_a;
    logic              neg_b;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   rem_diff;
    logic              fits;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start) state_next = div_by_zero ? S_DONE : S_CALC;
            S_CALC:  if (counter == CNT_W'(1)) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    // NOTE: sequential state uses <= so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_) state <= S_IDLE;
        else         state <= state_next;
    end

    assign accept      = (state == S_IDLE) && start && !flush;
    assign div_by_zero = (divisor == '0);
    assign neg_a       = signed_op & dividend[DATA_W-1];
    assign neg_b       = signed_op & divisor[DATA_W-1];
    assign mag_a       = neg_a ? -dividend : dividend;
    assign mag_b       = neg_b ? -divisor : divisor;

    // Partial remainder stays below the divisor, so the shifted value is below 2*divisor
    // and the borrow bit of the trial subtraction alone decides the quotient bit.
    assign rem_shift = {rem_q, quo_q[DATA_W-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs_q};
    assign fits      = ~rem_diff[DATA_W];
    assign rem_next  = fits ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
    assign quo_next  = {quo_q[DATA_W-2:0], fits};

    assign quo_fix = sign_q ? -quo_q : quo_q;
    assign rem_fix = sign_r ? -rem_q : rem_q;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            counter   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            counter  <= CNT_W'(DATA_W);
            rem_q    <= '0;
            quo_q    <= mag_a;
            dvs_q    <= mag_b;
            sign_q   <= neg_a ^ neg_b;
            sign_r   <= neg_a;
            div_zero <= div_by_zero;
            if (div_by_zero) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (!flush && state == S_CALC) begin
            rem_q   <= rem_next;
            quo_q   <= quo_next;
            counter <= counter - CNT_W'(1);
        end else if (!flush && state == S_FIX) begin
            quotient  <= quo_fix;
            remainder <= rem_fix;
        end
    end

    assign busy = (state == S_CALC) || (state == S_FIX);
    assign done = (state == S_DONE);

endmodule
